// File: rtl/control_fsm_if.sv
`default_nettype none
// ============================================================
// control_fsm_if : decoder/memory/datapath handshake bundle
// Rev 1.0
// ============================================================
interface control_fsm_if #(
  parameter int WIDTH = 32
);
  logic [6:0]       i_opcode;
  logic [2:0]       i_funct3;
  logic             i_imem_ack;
  logic             i_dmem_ack;
  logic             i_branch_taken;

  logic             o_imem_req;
  logic             o_ir_we;
  logic             o_dmem_req;
  logic             o_dmem_we;
  logic             o_alu_src_a;
  logic             o_alu_src_b;
  logic             o_rf_we;
  logic [1:0]       o_wb_sel;
  logic             o_pc_we;
  logic [1:0]       o_pc_sel;
  logic             o_illegal;
  logic [WIDTH-1:0] o_instret;

  modport slave (
    input  i_opcode, i_funct3, i_imem_ack, i_dmem_ack, i_branch_taken,
    output o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_alu_src_a,
           o_alu_src_b, o_rf_we, o_wb_sel, o_pc_we, o_pc_sel, o_illegal,
           o_instret
  );

  modport master (
    output i_opcode, i_funct3, i_imem_ack, i_dmem_ack, i_branch_taken,
    input  o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_alu_src_a,
           o_alu_src_b, o_rf_we, o_wb_sel, o_pc_we, o_pc_sel, o_illegal,
           o_instret
  );
endinterface
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================
// control_fsm : multi-cycle RV32I sequencing FSM with retire counter
// Rev 1.0
// ============================================================
module control_fsm #(
  parameter int WIDTH = 32
) (
  input  wire logic    i_clk,
  input  wire logic    i_rst_n,
  control_fsm_if.slave bus
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             w_legal;

  logic             imem_req_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             alu_src_a_q;
  logic             alu_src_b_q;
  logic             rf_we_q;
  logic [1:0]       wb_sel_q;
  logic             pc_we_q;
  logic [1:0]       pc_sel_q;
  logic             wb_branch_q;
  logic             illegal_q;
  logic [WIDTH-1:0] instret_q;

  // The instruction fields are captured only while decoding; every later
  // state works from the captured copy.
  always_comb begin
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    if (state_q == S_DECODE) begin
      opcode_d = bus.i_opcode;
      funct3_d = bus.i_funct3;
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (opcode_d)
      c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_OPIMM,
      c_OP_OP, c_OP_FENCE, c_OP_SYSTEM:
        w_legal = 1'b1;
      c_OP_LOAD:   w_legal = !((funct3_d == 3'd3) || (funct3_d >= 3'd6));
      c_OP_STORE:  w_legal = (funct3_d <= 3'd2);
      c_OP_BRANCH: w_legal = !((funct3_d == 3'd2) || (funct3_d == 3'd3));
      default:     w_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   if (bus.i_imem_ack) state_d = S_DECODE;
      S_DECODE:  state_d = w_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: state_d = ((opcode_q == c_OP_LOAD) || (opcode_q == c_OP_STORE))
                           ? S_MEM : S_WB;
      S_MEM:     if (bus.i_dmem_ack) state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up exactly with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      opcode_q    <= 7'd0;
      funct3_q    <= 3'd0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      alu_src_a_q <= 1'b0;
      alu_src_b_q <= 1'b0;
      rf_we_q     <= 1'b0;
      wb_sel_q    <= 2'd0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 2'd0;
      wb_branch_q <= 1'b0;
      illegal_q   <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      imem_req_q  <= (state_d == S_FETCH);
      dmem_req_q  <= (state_d == S_MEM);
      dmem_we_q   <= (state_d == S_MEM) && (opcode_d == c_OP_STORE);
      alu_src_a_q <= (state_d == S_EXECUTE) &&
                     (opcode_d inside {c_OP_AUIPC, c_OP_JAL, c_OP_BRANCH});
      alu_src_b_q <= (state_d == S_EXECUTE) && (opcode_d != c_OP_OP);
      rf_we_q     <= (state_d == S_WB) &&
                     !(opcode_d inside {c_OP_BRANCH, c_OP_STORE, c_OP_FENCE, c_OP_SYSTEM});
      if (state_d != S_WB)
        wb_sel_q <= 2'd0;
      else if ((opcode_d == c_OP_JAL) || (opcode_d == c_OP_JALR))
        wb_sel_q <= 2'd2;
      else if (opcode_d == c_OP_LOAD)
        wb_sel_q <= 2'd1;
      else
        wb_sel_q <= 2'd0;
      pc_we_q     <= (state_d == S_WB);
      if ((state_d == S_WB) && (opcode_d == c_OP_JAL))
        pc_sel_q <= 2'd1;
      else if ((state_d == S_WB) && (opcode_d == c_OP_JALR))
        pc_sel_q <= 2'd2;
      else
        pc_sel_q <= 2'd0;
      wb_branch_q <= (state_d == S_WB) && (opcode_d == c_OP_BRANCH);
      illegal_q   <= (state_d == S_TRAP);
      if (state_q == S_WB)
        instret_q <= instret_q + WIDTH'(1);
    end
  end

  assign bus.o_imem_req  = imem_req_q;
  assign bus.o_ir_we     = imem_req_q & bus.i_imem_ack;
  assign bus.o_dmem_req  = dmem_req_q;
  assign bus.o_dmem_we   = dmem_we_q;
  assign bus.o_alu_src_a = alu_src_a_q;
  assign bus.o_alu_src_b = alu_src_b_q;
  assign bus.o_rf_we     = rf_we_q;
  assign bus.o_wb_sel    = wb_sel_q;
  assign bus.o_pc_we     = pc_we_q;
  // Branch outcome arrives from the ALU during write-back itself.
  assign bus.o_pc_sel    = (wb_branch_q && bus.i_branch_taken) ? 2'd1 : pc_sel_q;
  assign bus.o_illegal   = illegal_q;
  assign bus.o_instret   = instret_q;

endmodule
`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: WIDTH, 32, instruction/counter width.
REQ-002 Ports (name  direction  width  meaning):
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_opcode  in  7  opcode field from the instruction decoder.
- i_funct3  in  3  funct3 field from the instruction decoder.
- i_imem_ack  in  1  instruction memory done; instruction valid this cycle.
- i_dmem_ack  in  1  data memory done; load data valid this cycle.
- i_branch_taken  in  1  ALU compare result for the current branch.
- o_imem_req  out  1  instruction fetch request.
- o_ir_we  out  1  instruction register load strobe.
- o_dmem_req  out  1  data memory request.
- o_dmem_we  out  1  data memory write (store).
- o_alu_src_a  out  1  0 = rs1, 1 = PC.
- o_alu_src_b  out  1  0 = rs2, 1 = immediate.
- o_rf_we  out  1  register file write strobe.
- o_wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4.
- o_pc_we  out  1  PC update strobe.
- o_pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) & ~1.
- o_illegal  out  1  sticky illegal-instruction flag.
- o_instret  out  WIDTH  retired-instruction counter.

Function
REQ-003 States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
REQ-004 IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-005 FETCH:
- o_imem_req=1 held until i_imem_ack=1.
- In the ack cycle: o_ir_we=1, then -> DECODE.
REQ-006 DECODE:
- Latch i_opcode and i_funct3 internally.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
- Legal opcode -> EXECUTE; any other opcode -> TRAP.
REQ-007 DECODE illegal checks also -> TRAP:
- LOAD with funct3 in {3, 6, 7}.
- STORE with funct3 > 2.
- BRANCH with funct3 in {2, 3}.
REQ-008 EXECUTE (1 cycle), ALU selects from latched opcode:
- AUIPC, JAL, BRANCH: a=PC.
- OP: b=rs2; all others b=imm.
- LOAD/STORE -> MEM; all others -> WB.
REQ-009 MEM:
- o_dmem_req=1 held until i_dmem_ack; o_dmem_we=1 only for STORE.
- Ack -> WB.
REQ-010 WB (1 cycle):
- o_pc_we=1 for all opcodes.
- o_rf_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; 0 for BRANCH, STORE, FENCE, SYSTEM.
- o_wb_sel: 2 for JAL/JALR, 1 for LOAD, else 0.
- o_pc_sel: 1 for JAL or (BRANCH and i_branch_taken); 2 for JALR; else 0.
- o_instret += 1 at end of WB, wrapping from 2^WIDTH-1 to 0.
- WB -> FETCH.
REQ-011 FENCE and SYSTEM are no-ops: they retire through EXECUTE -> WB.
REQ-012 TRAP:
- o_illegal=1; all strobes and requests 0.
- o_instret frozen; TRAP is left only by reset.
REQ-013 Strobe/request outputs are Moore-decoded from state and latched opcode; the only combinational input dependencies are o_ir_we (i_imem_ack) and o_pc_sel (i_branch_taken).
REQ-014 An ack arriving while its request is low is ignored.
REQ-015 o_imem_req and o_dmem_req are never asserted in the same cycle.

Reset
REQ-016 While i_rst_n=0, immediately and without clock:
- State = IDLE.
- All outputs 0, including o_instret and o_illegal.
- Latched opcode/funct3 = 0.
REQ-017 Reset asserted mid-fetch or mid-memory access drops the request the same instant; no strobe is issued for an outstanding ack.

Verification
REQ-018 Release reset, ack fetch after 3 wait cycles, opcode 0110011 -> IDLE, FETCH x4, DECODE, EXECUTE, WB; one cycle each of rf_we=1, wb_sel=0, pc_sel=0; instret=1.
REQ-019 LOAD (0000011, funct3=2), dmem ack after 2 cycles -> dmem_req high 3 cycles with dmem_we=0; WB rf_we=1, wb_sel=1.
REQ-020 BRANCH (1100011, funct3=0) with i_branch_taken=1, then again with 0 -> pc_sel=1 then pc_sel=0; rf_we=0 both times; instret +2.
REQ-021 Opcode 1111111, then LOAD with funct3=7 after reset -> TRAP each time; o_illegal=1; no further imem_req; instret unchanged; reset clears o_illegal.
REQ-022 Assert i_rst_n=0 during MEM with dmem_req=1 -> dmem_req=0 asynchronously; after release, first request is an instruction fetch.
REQ-023 Preload o_instret to 2^WIDTH-1 by forcing, retire one instruction -> o_instret=0.
